// File: rtl/gcd_ctrl.sv
// gcd_ctrl: Moore FSM sequencing a subtract-based GCD datapath.
// Ports: clk, rst (async high), start, gt/lt/eq flags in; LdA, LdB,
//        sel_in, sel1, sel2, busy, done, err, iter_cnt[15:0] out.
module gcd_ctrl #(
    parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        gt,
    input  logic        lt,
    input  logic        eq,
    output logic        LdA,
    output logic        LdB,
    output logic        sel_in,
    output logic        sel1,
    output logic        sel2,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CMP    = 3'd3,
        SUB_A  = 3'd4,
        SUB_B  = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] iter_cnt_q, iter_cnt_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            iter_cnt_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next state, step counter and error status.
    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_A;
                    iter_cnt_d = 16'd0;
                    err_d      = 1'b0;
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: state_d = CMP;
            CMP: begin
                // eq wins, then the step budget, then direction.
                if (eq) begin
                    state_d = DONE;
                end else if (iter_cnt_q == MAX_ITER) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (gt) begin
                    state_d = SUB_A;
                end else if (lt) begin
                    state_d = SUB_B;
                end else begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            SUB_A, SUB_B: begin
                state_d = CMP;
                // Saturating; CMP stops runs at MAX_ITER anyway.
                if (iter_cnt_q < MAX_ITER) begin
                    iter_cnt_d = iter_cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs decode from the state register only.
    always_comb begin
        LdA    = 1'b0;
        LdB    = 1'b0;
        sel_in = 1'b0;
        sel1   = 1'b0;
        sel2   = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state_q)
            IDLE: ;
            LOAD_A: begin
                sel_in = 1'b1;
                LdA    = 1'b1;
                busy   = 1'b1;
            end
            LOAD_B: begin
                sel_in = 1'b1;
                LdB    = 1'b1;
                busy   = 1'b1;
            end
            CMP: busy = 1'b1;
            SUB_A: begin
                sel2 = 1'b1;
                LdA  = 1'b1;
                busy = 1'b1;
            end
            SUB_B: begin
                sel1 = 1'b1;
                LdB  = 1'b1;
                busy = 1'b1;
            end
            DONE:    done = 1'b1;
            ERR:     done = 1'b1;
            default: ;
        endcase
    end

    // err_q is set on the CMP->ERR edge, so it already reads 1 in ERR,
    // 0 in DONE, and holds until the next accepted start.
    assign err      = err_q;
    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: directed bench for gcd_ctrl with a behavioural
// 16-bit GCD datapath model closing the loop on the flags.
module tb_gcd_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        gt, lt, eq;
    logic        LdA, LdB, sel_in, sel1, sel2;
    logic        busy, done, err;
    logic [15:0] iter_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // datapath model
    logic [15:0] op_a, op_b;
    logic [15:0] dp_a, dp_b;
    logic [15:0] data_in, s1, s2, bus;
    logic        kill;
    logic [7:0]  ctl;

    gcd_ctrl #(.MAX_ITER(16'd8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .gt(gt), .lt(lt), .eq(eq),
        .LdA(LdA), .LdB(LdB), .sel_in(sel_in),
        .sel1(sel1), .sel2(sel2),
        .busy(busy), .done(done), .err(err),
        .iter_cnt(iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_in = LdA ? op_a : op_b;
    assign s1  = sel1 ? dp_b : dp_a;
    assign s2  = sel2 ? dp_b : dp_a;
    assign bus = sel_in ? data_in : 16'(s1 - s2);
    assign gt  = !kill && (dp_a > dp_b);
    assign lt  = !kill && (dp_a < dp_b);
    assign eq  = !kill && (dp_a == dp_b);
    assign ctl = {LdA, LdB, sel_in, sel1, sel2, busy, done, err};

    always @(posedge clk) begin
        if (LdA) dp_a <= bus;
        if (LdB) dp_b <= bus;
    end

    localparam logic [15:0] C_IDLE = 16'b0000_0000;
    localparam logic [15:0] C_LDA  = 16'b1010_0100;
    localparam logic [15:0] C_LDB  = 16'b0110_0100;
    localparam logic [15:0] C_CMP  = 16'b0000_0100;
    localparam logic [15:0] C_SUBA = 16'b1000_1100;
    localparam logic [15:0] C_SUBB = 16'b0101_0100;
    localparam logic [15:0] C_DONE = 16'b0000_0010;
    localparam logic [15:0] C_ERR  = 16'b0000_0011;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise start in IDLE; returns positioned in cycle 1.
    task automatic go(input logic [15:0] a, input logic [15:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op_a  = 16'd0;
        op_b  = 16'd0;
        dp_a  = 16'd0;
        dp_b  = 16'd0;
        #12;
        chk("rst_ctl", 16'(ctl), C_IDLE);
        chk("rst_iter", iter_cnt, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ctl", 16'(ctl), C_IDLE);

        // 48,18: 4 steps, DONE in cycle 12
        go(16'd48, 16'd18);
        chk("g48_c1", 16'(ctl), C_LDA);
        tick();
        chk("g48_c2", 16'(ctl), C_LDB);
        tick();
        chk("g48_c3", 16'(ctl), C_CMP);
        chk("g48_c3_it", iter_cnt, 16'd0);
        tick();
        chk("g48_c4", 16'(ctl), C_SUBA);
        repeat (4) tick();
        chk("g48_c8", 16'(ctl), C_SUBB);
        chk("g48_c8_it", iter_cnt, 16'd2);
        repeat (4) tick();
        chk("g48_c12", 16'(ctl), C_DONE);
        chk("g48_it", iter_cnt, 16'd4);
        chk("g48_a", dp_a, 16'd6);
        chk("g48_b", dp_b, 16'd6);
        tick();
        chk("g48_c13", 16'(ctl), C_IDLE);
        chk("g48_hold", iter_cnt, 16'd4);

        // 7,7: eq at first CMP, DONE in cycle 4
        go(16'd7, 16'd7);
        tick();
        tick();
        chk("g77_c3", 16'(ctl), C_CMP);
        tick();
        chk("g77_c4", 16'(ctl), C_DONE);
        chk("g77_it", iter_cnt, 16'd0);
        chk("g77_a", dp_a, 16'd7);
        tick();

        // 0,5: lt forever, ERR in cycle 20 at MAX_ITER=8
        go(16'd0, 16'd5);
        repeat (17) tick();
        chk("g05_c18", 16'(ctl), C_SUBB);
        tick();
        chk("g05_c19", 16'(ctl), C_CMP);
        tick();
        chk("g05_c20", 16'(ctl), C_ERR);
        chk("g05_it", iter_cnt, 16'd8);
        repeat (3) tick();
        chk("g05_idle", 16'(ctl), 16'b0000_0001);
        chk("g05_ith", iter_cnt, 16'd8);

        // next start clears err and iter_cnt
        go(16'd7, 16'd7);
        chk("clr_c1", 16'(ctl), C_LDA);
        chk("clr_it", iter_cnt, 16'd0);
        repeat (4) tick();

        // start ignored in SUB_A and in DONE
        go(16'd48, 16'd18);
        repeat (3) tick();
        chk("ign_c4", 16'(ctl), C_SUBA);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_c5", 16'(ctl), C_CMP);
        chk("ign_c5_it", iter_cnt, 16'd1);
        repeat (7) tick();
        chk("ign_c12", 16'(ctl), C_DONE);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_c13", 16'(ctl), C_IDLE);
        tick();
        chk("ign_c14", 16'(ctl), C_IDLE);

        // no flag in CMP -> ERR
        go(16'd5, 16'd3);
        tick();
        tick();
        chk("nf_c3", 16'(ctl), C_CMP);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("nf_c4", 16'(ctl), C_ERR);
        tick();
        chk("nf_c5", 16'(ctl), 16'b0000_0001);

        // async reset mid SUB_B, then 9,6
        go(16'd48, 16'd18);
        repeat (7) tick();
        chk("ar_c8", 16'(ctl), C_SUBB);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_ctl", 16'(ctl), C_IDLE);
        chk("ar_it", iter_cnt, 16'd0);
        tick();
        chk("ar_hold", 16'(ctl), C_IDLE);
        rst = 1'b0;
        tick();
        go(16'd9, 16'd6);
        chk("g96_c1", 16'(ctl), C_LDA);
        repeat (6) tick();
        chk("g96_c7", 16'(ctl), C_CMP);
        tick();
        chk("g96_c8", 16'(ctl), C_DONE);
        chk("g96_a", dp_a, 16'd3);
        chk("g96_it", iter_cnt, 16'd2);
        tick();
        chk("g96_c9", 16'(ctl), C_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 Parameter: MAX_ITER, default 16'hFFFF, the maximum number of subtract steps before a timeout.
REQ-002 Port: clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port: rst, input, 1; reset is asynchronous and active-high.
REQ-004 Port: start, input, 1, requests a new GCD computation; sampled only in IDLE.
REQ-005 Ports: gt, lt, eq, inputs, 1 each, the datapath compare flags for A_out versus B_out.
REQ-006 Ports: LdA, LdB, outputs, 1 each, the load enables of datapath registers A and B.
REQ-007 Port: sel_in, output, 1; 1 selects data_in onto the bus, 0 selects the subtractor result.
REQ-008 Ports: sel1, sel2, outputs, 1 each, the subtractor operand selects; 0 selects A_out, 1 selects B_out.
REQ-009 Port: busy, output, 1, high while a computation is in progress.
REQ-010 Port: done, output, 1, a one-cycle pulse at completion (normal end or error).
REQ-011 Port: err, output, 1, error status of the last computation.
REQ-012 Port: iter_cnt, output, 16, the subtract steps performed in the current or last computation.

Function
REQ-013 The controller SHALL be a Moore FSM; the control outputs SHALL decode from the state only.
REQ-014 States SHALL be IDLE, LOAD_A, LOAD_B, CMP, SUB_A, SUB_B, DONE and ERR.
REQ-015 IDLE: all control outputs 0; start=1 -> LOAD_A, clear iter_cnt and err.
REQ-016 LOAD_A: sel_in=1, LdA=1; the source holds operand A on data_in this cycle; next state LOAD_B.
REQ-017 LOAD_B: sel_in=1, LdB=1; the source holds operand B on data_in this cycle; next state CMP.
REQ-018 CMP: no loads; flags evaluated with priority eq > gt > lt.
  - eq -> DONE.
  - Else if iter_cnt == MAX_ITER -> ERR.
  - Else gt -> SUB_A; else lt -> SUB_B.
  - No flag set -> ERR.
REQ-019 SUB_A: sel_in=0, sel1=0, sel2=1, LdA=1 (A <= A-B); iter_cnt +1; next state CMP.
REQ-020 SUB_B: sel_in=0, sel1=1, sel2=0, LdB=1 (B <= B-A); iter_cnt +1; next state CMP.
REQ-021 DONE: done=1 and err=0; next state IDLE unconditionally; the GCD is then valid on A_out (= B_out).
REQ-022 ERR: done=1 and err=1; next state IDLE unconditionally.
REQ-023 busy SHALL be 1 in LOAD_A, LOAD_B, CMP, SUB_A and SUB_B, and 0 in IDLE, DONE and ERR.
REQ-024 start SHALL be ignored in every state except IDLE, including in DONE and ERR.
REQ-025 err and iter_cnt SHALL hold their values after DONE or ERR until the next accepted start.
REQ-026 iter_cnt SHALL saturate and never wrap; it cannot exceed MAX_ITER because of REQ-018.
REQ-027 Latency: with N subtract steps, LOAD_A is cycle 1 after start is sampled and DONE is cycle 4+2N.
REQ-028 The block SHALL contain no datapath logic; the operand width (16 bits) is the datapath's concern only.

Reset
REQ-029 While rst=1, asynchronously:
  - state = IDLE.
  - LdA, LdB, sel_in, sel1, sel2, busy, done, err = 0.
  - iter_cnt = 0.
REQ-030 A reset mid-computation SHALL abandon the computation with no done pulse; the first start after rst falls SHALL be accepted normally.

Verification
REQ-031 A=48, B=18 -> 4 subtract steps (30, 12, 6, 6):
  - done=1 in cycle 12, err=0, iter_cnt=4.
  - A_out=6 at done.
REQ-032 A=7, B=7 -> CMP sees eq immediately:
  - done=1 in cycle 4, iter_cnt=0, err=0.
  - No LdA/LdB pulse after LOAD_B.
REQ-033 MAX_ITER=8, A=0, B=5 -> lt persists (B-0):
  - ERR with done=1, err=1 in cycle 20, iter_cnt=8.
  - err stays 1 in IDLE until the next start.
REQ-034 Pulse start during SUB_A of a run, and again in the DONE cycle:
  - Both pulses are ignored.
  - Exactly one done pulse; return to IDLE.
REQ-035 Force gt=lt=eq=0 in CMP -> next cycle ERR, done=1, err=1.
REQ-036 Assert rst asynchronously mid-SUB_B:
  - All outputs go to 0 immediately, with no done pulse.
  - A subsequent start with A=9, B=6 completes with done in cycle 8 and A_out=3.
